// File: rtl/m65c02a_intc.sv
// m65c02a_intc
//   Eight-input interrupt controller that sits upstream of the M65C02A core's
//   nIRQ input. Each request is synchronised, captured as level or rising-edge,
//   masked, and then reduced to one registered active-low nIRQ. A
//   priority-encoded source index lets the ISR dispatch without polling.
//
// Ports
//   Clk      system clock, single domain
//   Rst      synchronous reset, active-high
//   Sel      register window select from the address decoder
//   WE, RE   write / read strobes, each qualified by Sel
//   Addr     register offset (0 PEND, 1 ENA, 2 MODE, 3 SWSET, 4 IDX, 5 ACTIVE)
//   DI       write data from the core
//   DO       registered read data, valid the cycle after a read strobe
//   IRQ_In   asynchronous requests, active-high, bit 0 has highest priority
//   nIRQ     registered interrupt request to the core, active-low
//   IRQ_Idx  lowest set index of the active vector, 0 when none is active
module m65c02a_intc #(
    parameter int N_SRC = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Sel,
    input  logic                     WE,
    input  logic                     RE,
    input  logic [2:0]               Addr,
    input  logic [7:0]               DI,
    output logic [7:0]               DO,
    input  logic [N_SRC-1:0]         IRQ_In,
    output logic                     nIRQ,
    output logic [$clog2(N_SRC)-1:0] IRQ_Idx
);

    localparam int IDX_W = $clog2(N_SRC);

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_ENA    = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_SWSET  = 3'd3;
    localparam logic [2:0] A_IDX    = 3'd4;
    localparam logic [2:0] A_ACTIVE = 3'd5;

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] ena;
    logic [N_SRC-1:0] mode;

    logic             wr_en;
    logic             rd_en;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] sw_set;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] act;
    logic             any_act;
    logic [7:0]       rd_data;

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [N_SRC-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        wr_en    = Sel & WE;
        rd_en    = Sel & RE;
        pend_clr = (wr_en && (Addr == A_PEND))  ? DI : '0;
        sw_set   = (wr_en && (Addr == A_SWSET)) ? DI : '0;
        edge_set = (sync2 & ~prev) | sw_set;

        // The mode in force before this edge decides the update, so a switch
        // to level loads sync2 one cycle later and a switch to edge keeps
        // whatever was captured. Set is OR-ed after the clear so it wins.
        pend_next = (mode & (edge_set | (pend & ~pend_clr))) | (~mode & sync2);

        act     = pend & ena;
        any_act = |act;
        IRQ_Idx = prio_enc(act);

        case (Addr)
            A_PEND:   rd_data = pend;
            A_ENA:    rd_data = ena;
            A_MODE:   rd_data = mode;
            A_IDX:    rd_data = {any_act, 4'b0000, IRQ_Idx};
            A_ACTIVE: rd_data = act;
            default:  rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            pend  <= '0;
            ena   <= '0;
            mode  <= '0;
            DO    <= 8'h00;
            nIRQ  <= 1'b1;
        end else begin
            // synchroniser -> edge history -> pending
            sync1 <= IRQ_In;
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= pend_next;

            if (wr_en) begin
                case (Addr)
                    A_ENA:   ena  <= DI;
                    A_MODE:  mode <= DI;
                    default: ;
                endcase
            end

            // rd_data is built from pre-edge state, so a combined write+read
            // returns the old contents.
            if (rd_en) begin
                DO <= rd_data;
            end

            nIRQ <= ~any_act;
        end
    end

endmodule
